// File: rtl/vga_sync_decoder.sv
// Recovers line/frame timing from an async negative-polarity hsync/vsync + BGR stream; emits x/y/de/rgb.
// Fixed 4-clock input-to-output latency on every field; free-running, no backpressure.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_ACT_BEGIN = 143,
  parameter int H_ACT_END   = 783,
  parameter int V_TOTAL     = 525,
  parameter int V_ACT_BEGIN = 34,
  parameter int V_ACT_END   = 514,
  parameter int ERR_LIMIT   = 4
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [2:0]  rgb_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        de,
  output logic [2:0]  rgb_out,
  output logic        frame_start,
  output logic        line_err,
  output logic        locked,
  output logic [10:0] h_period,
  output logic [9:0]  v_lines
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t      state;
  logic [2:0]  hs_sync;
  logic [2:0]  vs_sync;
  logic [2:0]  rgb_s1;
  logic [2:0]  rgb_s2;
  logic [2:0]  rgb_s3;
  logic [10:0] hcnt;
  logic [10:0] hwidth;
  logic [9:0]  vcnt;
  logic        vpend;
  logic        frame_ok;
  logic [3:0]  errcnt;
  logic        frame_start_d;
  logic        line_err_d;

  logic        h_fall;
  logic        v_fall;
  logic        restart;
  logic        line_bad;
  logic        frame_bad;
  logic        overflow;
  logic        active;
  logic [11:0] hcnt_p1;
  logic [10:0] vcnt_p1;

  assign h_fall    = hs_sync[2] & ~hs_sync[1];
  assign v_fall    = vs_sync[2] & ~vs_sync[1];
  assign restart   = h_fall & (vpend | v_fall);
  assign hcnt_p1   = {1'b0, hcnt} + 12'd1;
  assign vcnt_p1   = {1'b0, vcnt} + 11'd1;
  assign line_bad  = (hcnt_p1 != 12'(H_TOTAL)) || (hwidth != 11'(H_SYNC));
  assign frame_bad = (vcnt_p1 != 11'(V_TOTAL));
  // Fires on the step into saturation, so a fall arriving on a saturated count still restarts normally
  assign overflow  = (~h_fall & (hcnt == 11'd2046)) | (h_fall & ~restart & (vcnt == 10'd1022));
  assign active    = (hcnt >= 11'(H_ACT_BEGIN)) && (hcnt < 11'(H_ACT_END)) &&
                     (vcnt >= 10'(V_ACT_BEGIN)) && (vcnt < 10'(V_ACT_END));
  assign locked    = (state == LOCKED);

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      hs_sync       <= 3'b111;
      vs_sync       <= 3'b111;
      rgb_s1        <= 3'd0;
      rgb_s2        <= 3'd0;
      rgb_s3        <= 3'd0;
      hcnt          <= 11'd0;
      hwidth        <= 11'd0;
      vcnt          <= 10'd0;
      vpend         <= 1'b0;
      h_period      <= 11'd0;
      v_lines       <= 10'd0;
      frame_start_d <= 1'b0;
      line_err_d    <= 1'b0;
      frame_start   <= 1'b0;
      line_err      <= 1'b0;
      de            <= 1'b0;
      rgb_out       <= 3'd0;
      x             <= 10'd0;
      y             <= 10'd0;
    end else begin
      hs_sync <= {hs_sync[1:0], hsync_in};
      vs_sync <= {vs_sync[1:0], vsync_in};
      rgb_s1  <= rgb_in;
      rgb_s2  <= rgb_s1;
      rgb_s3  <= rgb_s2;

      if (h_fall) begin
        hcnt     <= 11'd0;
        hwidth   <= 11'd1;
        h_period <= hcnt_p1[10:0];
      end else begin
        if (hcnt != 11'h7ff) hcnt <= hcnt + 11'd1;
        if (!hs_sync[1] && hwidth != 11'h7ff) hwidth <= hwidth + 11'd1;
      end

      if (restart) begin
        vpend   <= 1'b0;
        vcnt    <= 10'd0;
        v_lines <= vcnt_p1[9:0];
      end else begin
        if (v_fall) vpend <= 1'b1;
        if (h_fall && vcnt != 10'h3ff) vcnt <= vcnt + 10'd1;
      end

      // Event pulses take one extra stage to line up with the pixel they belong to
      frame_start_d <= restart;
      line_err_d    <= h_fall & line_bad & (state != SEARCH);
      frame_start   <= frame_start_d;
      line_err      <= line_err_d;

      de      <= active & (state == LOCKED);
      rgb_out <= (active && state == LOCKED) ? rgb_s3 : 3'd0;
      x       <= 10'(hcnt - 11'(H_ACT_BEGIN));
      y       <= 10'(vcnt - 10'(V_ACT_BEGIN));
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SEARCH;
      errcnt   <= 4'd0;
      frame_ok <= 1'b0;
    end else if (overflow) begin
      state <= SEARCH;
    end else begin
      case (state)
        SEARCH: begin
          if (restart) begin
            state    <= VERIFY;
            errcnt   <= 4'd0;
            frame_ok <= 1'b1;
          end
        end
        VERIFY: begin
          // The line closed by a restart still belongs to the frame being judged
          if (restart) begin
            if (frame_ok && !line_bad && !frame_bad) begin
              state  <= LOCKED;
              errcnt <= 4'd0;
            end
            frame_ok <= 1'b1;
          end else if (h_fall && line_bad) begin
            frame_ok <= 1'b0;
          end
        end
        LOCKED: begin
          if (restart && frame_bad) begin
            state <= SEARCH;
          end else if (h_fall) begin
            if (line_bad) begin
              errcnt <= errcnt + 4'd1;
              if (errcnt + 4'd1 == 4'(ERR_LIMIT)) state <= SEARCH;
            end else begin
              errcnt <= 4'd0;
            end
          end
        end
        default: state <= SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled 40x20 raster: a frame table drives the stream and
// carries each frame's expected lock/error/measurement results; pixels are checked 4 clocks later.
module tb_vga_sync_decoder;

  localparam int H_TOT = 40;
  localparam int H_SYN = 6;
  localparam int H_AB  = 10;
  localparam int H_AE  = 34;
  localparam int V_TOT = 20;
  localparam int V_AB  = 3;
  localparam int V_AE  = 17;
  localparam int ACT_PER_FRAME = (H_AE - H_AB) * (V_AE - V_AB);

  logic        clock;
  logic        rst_n;
  logic        hsync_in;
  logic        vsync_in;
  logic [2:0]  rgb_in;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        de;
  logic [2:0]  rgb_out;
  logic        frame_start;
  logic        line_err;
  logic        locked;
  logic [10:0] h_period;
  logic [9:0]  v_lines;

  vga_sync_decoder #(
    .H_TOTAL(H_TOT), .H_SYNC(H_SYN), .H_ACT_BEGIN(H_AB), .H_ACT_END(H_AE),
    .V_TOTAL(V_TOT), .V_ACT_BEGIN(V_AB), .V_ACT_END(V_AE), .ERR_LIMIT(4)
  ) dut (
    .clock(clock), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in), .rgb_in(rgb_in),
    .x(x), .y(y), .de(de), .rgb_out(rgb_out), .frame_start(frame_start), .line_err(line_err),
    .locked(locked), .h_period(h_period), .v_lines(v_lines)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One frame of stimulus plus what the decoder should report for it
  typedef struct {
    int lines;
    int bad_first;
    int n_bad;
    int bad_len;
    int bad_hw;
    int vs_lead;
    bit lk;
    bit chk;
    int exp_lerr;
    bit exp_lock;
    int probe_line;
    int exp_hp;
    int exp_vl;
  } frame_vec_t;

  typedef struct {
    bit         act;
    bit         lk;
    bit         chk;
    logic [9:0] ex;
    logic [9:0] ey;
    logic [2:0] rgb;
  } exp_t;

  frame_vec_t tbl [16];
  exp_t       pipe [$];
  int n_chk  = 0;
  int n_fail = 0;
  int pix_err, de_cnt, lerr_cnt, fs_cnt;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic hs, input logic vs, input exp_t e_in);
    exp_t e;
    @(negedge clock);
    if (pipe.size() == 4) begin
      e = pipe.pop_front();
      if (e.chk) begin
        if (de !== (e.act & e.lk)) pix_err++;
        else if (de === 1'b1) begin
          if (x !== e.ex || y !== e.ey || rgb_out !== e.rgb) pix_err++;
          de_cnt++;
        end else if (rgb_out !== 3'd0) pix_err++;
      end
    end
    if (line_err === 1'b1) lerr_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
    hsync_in = hs;
    vsync_in = vs;
    rgb_in   = e_in.rgb;
    pipe.push_back(e_in);
  endtask

  task automatic drive_frame(input frame_vec_t v, input int idx, input int n_lines);
    exp_t e;
    int   len, hw;
    bit   bad;
    logic vs;
    pix_err = 0; de_cnt = 0; lerr_cnt = 0; fs_cnt = 0;
    for (int ln = 0; ln < n_lines; ln++) begin
      bad = (ln >= v.bad_first) && (ln < v.bad_first + v.n_bad);
      len = bad ? v.bad_len : H_TOT;
      hw  = bad ? v.bad_hw  : H_SYN;
      for (int p = 0; p < len; p++) begin
        vs    = !((ln <= 1) || (ln == v.lines - 1 && p >= len - v.vs_lead));
        e.act = (ln >= V_AB) && (ln < V_AE) && (p >= H_AB) && (p < H_AE);
        e.ex  = 10'(p - H_AB);
        e.ey  = 10'(ln - V_AB);
        e.rgb = 3'($urandom_range(7));
        e.lk  = v.lk;
        e.chk = v.chk;
        step(p >= hw, vs, e);
        if (ln == v.probe_line && p == 20) begin
          check($sformatf("f%0d_h_period", idx), h_period, v.exp_hp);
          check($sformatf("f%0d_v_lines", idx), v_lines, v.exp_vl);
        end
      end
    end
  endtask

  task automatic check_frame(input int i);
    check($sformatf("f%0d_frame_start_count", i), fs_cnt, 1);
    check($sformatf("f%0d_line_err_count", i), lerr_cnt, tbl[i].exp_lerr);
    check($sformatf("f%0d_locked_end", i), locked, tbl[i].exp_lock);
    if (tbl[i].chk) begin
      check($sformatf("f%0d_de_count", i), de_cnt, tbl[i].lk ? ACT_PER_FRAME : 0);
      check($sformatf("f%0d_pixel_errors", i), pix_err, 0);
    end
  endtask

  initial begin
    exp_t idle_e;
    rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 3'd0;
    idle_e = '{act: 1'b0, lk: 1'b0, chk: 1'b0, ex: 10'd0, ey: 10'd0, rgb: 3'd0};

    //         lines bf nb len hw lead lk    chk   lerr lock  prb hp  vl
    tbl[0]  = '{20,  0, 0, 40, 6, 0,  1'b0, 1'b1, 0,   1'b0, 10, 40, 1};
    tbl[1]  = '{20,  0, 0, 40, 6, 0,  1'b1, 1'b1, 0,   1'b1, 10, 40, 20};
    tbl[2]  = '{20,  0, 0, 40, 6, 7,  1'b1, 1'b1, 0,   1'b1, 10, 40, 20};
    tbl[3]  = '{20,  5, 1, 39, 6, 0,  1'b1, 1'b1, 1,   1'b1, 6,  39, 20};
    tbl[4]  = '{20,  5, 4, 39, 6, 0,  1'b0, 1'b0, 4,   1'b0, 10, 40, 20};
    tbl[5]  = '{20,  0, 0, 40, 6, 0,  1'b0, 1'b1, 0,   1'b0, 10, 40, 20};
    tbl[6]  = '{20,  0, 0, 40, 6, 0,  1'b1, 1'b1, 0,   1'b1, 10, 40, 20};
    tbl[7]  = '{19,  0, 0, 40, 6, 0,  1'b1, 1'b1, 0,   1'b1, 10, 40, 20};
    tbl[8]  = '{20,  0, 0, 40, 6, 0,  1'b0, 1'b1, 0,   1'b0, 10, 40, 19};
    tbl[9]  = '{20,  5, 1, 40, 5, 0,  1'b0, 1'b1, 1,   1'b0, 10, 40, 20};
    tbl[10] = '{20,  0, 0, 40, 6, 0,  1'b0, 1'b1, 0,   1'b0, 10, 40, 20};
    tbl[11] = '{20,  0, 0, 40, 6, 0,  1'b1, 1'b1, 0,   1'b1, 10, 40, 20};
    tbl[12] = '{20,  0, 0, 40, 6, 0,  1'b0, 1'b1, 0,   1'b0, 10, 40, 20};
    tbl[13] = '{20,  0, 0, 40, 6, 0,  1'b1, 1'b1, 0,   1'b1, 10, 40, 20};
    tbl[14] = '{20,  0, 0, 40, 6, 0,  1'b0, 1'b1, 0,   1'b0, 10, 40, 1};
    tbl[15] = '{20,  0, 0, 40, 6, 0,  1'b1, 1'b1, 0,   1'b1, 10, 40, 20};

    repeat (3) @(negedge clock);
    check("reset_outputs", {x, y, de, rgb_out, frame_start, line_err, locked, h_period, v_lines}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive_frame(tbl[i], i, tbl[i].lines);
      check_frame(i);
    end

    // hsync stuck high long enough to saturate the line counter
    repeat (2100) step(1'b1, 1'b1, idle_e);
    check("idle_locked", locked, 0);
    check("idle_de", de, 0);

    for (int i = 12; i < 14; i++) begin
      drive_frame(tbl[i], i, tbl[i].lines);
      check_frame(i);
    end

    // Partial locked frame, then a reset pulse in the middle of a line
    drive_frame(tbl[13], 99, 5);
    check("partial_pixel_errors", pix_err, 0);
    check("partial_locked", locked, 1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             {x, y, de, rgb_out, frame_start, line_err, locked, h_period, v_lines}, 0);
    hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (3) @(negedge clock);
    check("held_reset_outputs", {x, y, de, rgb_out, frame_start, line_err, locked, h_period, v_lines}, 0);
    rst_n = 1'b1;
    pipe.delete();

    for (int i = 14; i < 16; i++) begin
      drive_frame(tbl[i], i, tbl[i].lines);
      check_frame(i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
